dq_reg_bank: RTL and testbench
==============================

// Module: dq_reg_bank
// PURPOSE
//   Parametrised storage bank of DEPTH words x WIDTH bits, clocked on clk.
//   Successor to the fixed 4-bit DQ latch array: adds addressing, registered reads,
//   per-word valid bits and a sequenced bulk-clear engine. Sits between a bus-side
//   controller and datapath logic as a small scratchpad/register file.
// PARAMETERS
//   WIDTH   4    bits per word (>=1)
//   DEPTH   16   number of words (>=2, need not be a power of two)
//   ADDR_W  $clog2(DEPTH)  address width; derived, not overridden
// PORTS
//   clk       in   1       clock, all state updates on rising edge
//   rst       in   1       synchronous, active-high reset
//   wr_en     in   1       write request this cycle
//   wr_addr   in   ADDR_W  write address
//   wr_data   in   WIDTH   write data
//   rd_en     in   1       read request this cycle
//   rd_addr   in   ADDR_W  read address
//   rd_data   out  WIDTH   read data, registered
//   rd_valid  out  1       1-cycle pulse: rd_data carries result of a read
//   clr_req   in   1       start bulk clear (sampled in IDLE only)
//   busy      out  1       bulk clear in progress
// BEHAVIOUR
//   Reset (rst=1 at edge): rd_data=0, rd_valid=0, busy=0, all word-valid bits=0,
//     clear counter=0, FSM->IDLE. Word storage itself is not reset.
//     Reset mid-clear aborts the clear; all valid bits are 0 after reset anyway.
//   Write: wr_en=1 at edge N, addr<DEPTH -> mem[addr]=wr_data, valid[addr]=1.
//     Visible to a read issued at edge N+1 or later.
//   Read: rd_en=1 at edge N -> at edge N+1 rd_valid=1, rd_data = valid[addr] ?
//     mem[addr] : 0. Latency 1 cycle. rd_data holds its value when rd_en=0;
//     rd_valid=0 on any cycle without an accepted read.
//   Out-of-range address (addr>=DEPTH): write dropped; read returns rd_data=0, rd_valid=1.
//   Same-cycle read and write, different address: both performed.
//   Same-cycle read and write, same address: see CONFIGURATION.
//   FSM states: IDLE, CLEAR.
//     IDLE: clr_req=1 -> CLEAR, counter=0, busy=1 from next cycle. Any wr_en/rd_en
//       in the same cycle as clr_req is dropped (clear wins; rd_valid stays 0).
//     CLEAR: each cycle valid[counter]=0, counter++; after clearing index DEPTH-1
//       -> IDLE, busy=0. Clear takes exactly DEPTH cycles of busy=1.
//     While busy: wr_en, rd_en, clr_req ignored; rd_valid=0; rd_data held.
//   Counter wraps to 0 on return to IDLE; never addresses >=DEPTH.
// CONFIGURATION
//   DQ_BANK_BYPASS_EN defined: same-cycle read+write to same in-range address
//     returns wr_data at N+1 (write-to-read forwarding).
//   Not defined: the read returns the pre-write contents (old mem if valid,
//     else 0); the write still takes effect.
// TESTING
//   1 Reset, then read addr 3 -> rd_valid=1 next cycle, rd_data=0 (word invalid).
//   2 Write 4'hA to addr 5, read addr 5 next cycle -> rd_data=4'hA one cycle later.
//   3 Write 4'h6 to addr 2 and read addr 2 same cycle (prior contents 4'h1 valid)
//     -> rd_data=4'h6 with DQ_BANK_BYPASS_EN, 4'h1 without.
//   4 Fill addrs 0..15 with addr value, pulse clr_req -> busy=1 for 16 cycles,
//     writes/reads during busy ignored (rd_valid=0); afterwards every read returns 0.
//   5 DEPTH=12: write 4'hF to addr 13 -> dropped; read 13 -> rd_data=0, rd_valid=1.
//   6 Assert rst at 5th cycle of clear -> busy=0 next cycle, FSM IDLE,
//     clr_req then restarts a full DEPTH-cycle clear.

Source files
------------

// File: rtl/dq_reg_bank.sv
// Purpose : DEPTH x WIDTH scratchpad with per-word valid bits and a sequenced bulk-clear engine.
// Latency : reads return one cycle after rd_en_i (rd_valid_o pulse); writes visible to the next read.
// Backpr. : none; while busy_o=1 every request (wr/rd/clr) is dropped and rd_data_o holds.
//
// Ports:
//   clk_i, rst_i                   clock; synchronous active-high reset
//   wr_en_i, wr_addr_i, wr_data_i  write port (out-of-range addresses dropped)
//   rd_en_i, rd_addr_i             read request
//   rd_data_o, rd_valid_o          registered read data and 1-cycle result strobe
//   clr_req_i, busy_o              start bulk clear (IDLE only); clear in progress
//
// Build option: define DQ_BANK_BYPASS_EN to forward wr_data_i to a same-cycle read of the
// same in-range address; otherwise such a read returns the pre-write contents.
module dq_reg_bank #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]  wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [WIDTH-1:0]  rd_data_o,
  output logic              rd_valid_o,
  input  logic              clr_req_i,
  output logic              busy_o
);

  // One extra bit so a non-power-of-two DEPTH compares cleanly against the address.
  localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IX = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [DEPTH-1:0]  valid_q;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  rd_data_q;
  logic              rd_valid_q;
  logic              busy_q;

  logic              wr_in_range;
  logic              rd_in_range;
  logic              idle_acc;
  logic              wr_acc;
  logic              rd_acc;
  logic [WIDTH-1:0]  rd_data_d;

  always_comb begin
    wr_in_range = {1'b0, wr_addr_i} < DEPTH_W;
    rd_in_range = {1'b0, rd_addr_i} < DEPTH_W;
    // A clear request in IDLE swallows any same-cycle read or write.
    idle_acc    = (state_q == S_IDLE) && !clr_req_i;
    wr_acc      = idle_acc && wr_en_i && wr_in_range;
    rd_acc      = idle_acc && rd_en_i;

    // Invalid or out-of-range words read as zero; mem_q is read before this
    // edge's write lands, so the non-forwarding build sees the old contents.
    rd_data_d = '0;
    if (rd_in_range && valid_q[rd_addr_i]) begin
      rd_data_d = mem_q[rd_addr_i];
    end
`ifdef DQ_BANK_BYPASS_EN
    if (rd_in_range && wr_acc && (wr_addr_i == rd_addr_i)) begin
      rd_data_d = wr_data_i;
    end
`endif
  end

  // Word storage is deliberately left out of reset; valid_q masks stale data.
  always_ff @(posedge clk_i) begin
    if (!rst_i && wr_acc) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      valid_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (clr_req_i) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end else begin
            if (rd_acc) begin
              rd_valid_q <= 1'b1;
              rd_data_q  <= rd_data_d;
            end
            if (wr_acc) begin
              valid_q[wr_addr_i] <= 1'b1;
            end
          end
        end
        S_CLEAR: begin
          // One word per cycle, so the clear lasts exactly DEPTH busy cycles.
          valid_q[cnt_q] <= 1'b0;
          if (cnt_q == LAST_IX) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + ADDR_W'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_dq_reg_bank.sv
// Purpose : bench for dq_reg_bank; a DEPTH=16 and a DEPTH=12 instance share one stimulus stream.
// Latency : expected outputs are predicted per edge and compared on the following falling edge.
// Backpr. : n/a.
module tb_dq_reg_bank;

`ifdef DQ_BANK_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [3:0] wr_data;
  logic       rd_en;
  logic [3:0] rd_addr;
  logic       clr_req;
  logic [3:0] rdd [2];
  logic       rdv [2];
  logic       bsy [2];

  int total = 0;
  int bad   = 0;
  string phase = "init";

  // Reference model: plain arrays plus a "busy cycles remaining" count per instance.
  int dep [2] = '{16, 12};
  int mdat [2][16];
  bit mval [2][16];
  int mleft [2];
  int erd [2];
  bit erv [2];

  dq_reg_bank #(.WIDTH(4), .DEPTH(16)) dut16 (
    .clk_i(clk), .rst_i(rst),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .rd_en_i(rd_en), .rd_addr_i(rd_addr),
    .rd_data_o(rdd[0]), .rd_valid_o(rdv[0]),
    .clr_req_i(clr_req), .busy_o(bsy[0])
  );

  dq_reg_bank #(.WIDTH(4), .DEPTH(12)) dut12 (
    .clk_i(clk), .rst_i(rst),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .rd_en_i(rd_en), .rd_addr_i(rd_addr),
    .rd_data_o(rdd[1]), .rd_valid_o(rdv[1]),
    .clr_req_i(clr_req), .busy_o(bsy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, advance the model at the edge, compare on the falling edge.
  task automatic cyc(input bit we, input int wa, input int wd,
                     input bit re, input int ra, input bit clr, input bit r);
    wr_en   = we;
    wr_addr = 4'(wa);
    wr_data = 4'(wd);
    rd_en   = re;
    rd_addr = 4'(ra);
    clr_req = clr;
    rst     = r;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        for (int i = 0; i < 16; i++) mval[k][i] = 1'b0;
        mleft[k] = 0;
        erv[k]   = 1'b0;
        erd[k]   = 0;
      end else if (mleft[k] > 0) begin
        mval[k][dep[k] - mleft[k]] = 1'b0;
        mleft[k]--;
        erv[k] = 1'b0;
      end else if (clr) begin
        mleft[k] = dep[k];
        erv[k]   = 1'b0;
      end else begin
        erv[k] = re;
        if (re) begin
          if (ra >= dep[k])                    erd[k] = 0;
          else if (BYPASS && we && wa == ra)   erd[k] = wd;
          else if (mval[k][ra])                erd[k] = mdat[k][ra];
          else                                 erd[k] = 0;
        end
        if (we && wa < dep[k]) begin
          mdat[k][wa] = wd;
          mval[k][wa] = 1'b1;
        end
      end
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s.d%0d.rd_valid", phase, dep[k]), 32'(rdv[k]), 32'(erv[k]));
      chk($sformatf("%s.d%0d.busy", phase, dep[k]), 32'(bsy[k]), 32'(mleft[k] > 0));
      chk($sformatf("%s.d%0d.rd_data", phase, dep[k]), 32'(rdd[k]), 32'(erd[k]));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    wr_en = 0; wr_addr = 0; wr_data = 0; rd_en = 0; rd_addr = 0; clr_req = 0; rst = 1;
    for (int k = 0; k < 2; k++) begin
      mleft[k] = 0; erd[k] = 0; erv[k] = 0;
      for (int i = 0; i < 16; i++) begin
        mdat[k][i] = 0; mval[k][i] = 0;
      end
    end

    phase = "reset";
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);

    phase = "rd_invalid";
    cyc(0, 0, 0, 1, 3, 0, 0);
    idle(1);

    phase = "wr_rd";
    cyc(1, 5, 4'hA, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 5, 0, 0);
    idle(1);

    phase = "same_addr";
    cyc(1, 2, 4'h1, 0, 0, 0, 0);
    cyc(1, 2, 4'h6, 1, 2, 0, 0);
    cyc(0, 0, 0, 1, 2, 0, 0);
    cyc(1, 7, 4'h3, 1, 2, 0, 0);
    idle(1);

    phase = "fill_clear";
    for (int a = 0; a < 16; a++) cyc(1, a, a, 0, 0, 0, 0);
    cyc(1, 4, 4'h9, 1, 4, 1, 0);
    for (int i = 0; i < 18; i++) cyc(1, i % 16, 4'hF, 1, i % 16, i[0], 0);
    for (int a = 0; a < 16; a++) cyc(0, 0, 0, 1, a, 0, 0);

    phase = "oor";
    cyc(1, 13, 4'hF, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 13, 0, 0);
    cyc(1, 11, 4'h5, 1, 12, 0, 0);
    cyc(0, 0, 0, 1, 11, 0, 0);

    phase = "rst_mid_clear";
    cyc(0, 0, 0, 0, 0, 1, 0);
    idle(4);
    cyc(0, 0, 0, 0, 0, 0, 1);
    idle(1);
    cyc(0, 0, 0, 0, 0, 1, 0);
    idle(18);

    phase = "random";
    for (int i = 0; i < 3000; i++) begin
      int wa, ra;
      wa = $urandom_range(0, 15);
      ra = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 15);
      cyc($urandom_range(0, 1), wa, $urandom_range(0, 15),
          $urandom_range(0, 1), ra,
          $urandom_range(0, 59) == 0,
          $urandom_range(0, 299) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
